led_frame_loader: RTL
=====================

# led_frame_loader

Sequencer that loads a parallel LED frame into the cascaded serial-in LED shift-register chain, MSB first. It accepts a frame over a valid/ready handshake, drives the serial data line and the active-low shift enable for exactly one bit per cycle, then pulses a latch strobe so the LED drivers update in one step. It sits between the frame source (pattern or host logic) and the shift-register chain. It can also periodically re-send the last frame to refresh the chain.

## Interface
- WIDTH, 8, bits per shift-register stage; must be ≥ 2
- CHAIN, 2, number of cascaded stages; total frame length N = WIDTH*CHAIN
- REFRESH_PERIOD, 1024, cycles from one latch pulse to the next auto-refresh request; must be ≥ N+2
- clk  in  1  rising-edge clock shared with the shift-register chain
- rst_n  in  1  asynchronous, active-low reset
- frame_data  in  N  frame; bit N-1 is shifted first and ends in the far end of the chain
- frame_valid  in  1  source has a frame
- frame_ready  out  1  loader can accept a frame
- refresh_en  in  1  enables periodic re-send of the held frame
- sr_data  out  1  serial data to the chain
- sr_en  out  1  shift enable, active low; the chain shifts on every rising clk while low
- latch  out  1  one-cycle output-update strobe
- busy  out  1  high in SHIFT or LATCH

## Operation
- States: IDLE, SHIFT, LATCH. All outputs are registered or decoded from state only. No output has a combinational path from an input.
- Reset (async, rst_n=0):
  - state=IDLE, frame_ready=1, sr_en=1, sr_data=0, latch=0, busy=0.
  - Bit counter = 0, hold register = 0, refresh counter = 0, hold_valid = 0.
- IDLE:
  - frame_ready=1.
  - On frame_valid & frame_ready: copy frame_data into the hold register, set hold_valid=1, go to SHIFT.
  - Otherwise, if refresh_en & hold_valid & refresh counter has expired: go to SHIFT using the existing hold register.
  - A new frame has priority over a refresh in the same cycle, and it restarts the refresh counter.
- SHIFT:
  - sr_en=0, frame_ready=0.
  - sr_data = hold register bit (N-1-k) in the k-th SHIFT cycle, k=0..N-1.
  - After N cycles, go to LATCH.
- LATCH:
  - sr_en=1, latch=1 for exactly one cycle, sr_data=0.
  - Reset the refresh counter to 0, then go to IDLE.
- Refresh counter:
  - Counts up in IDLE only and saturates at REFRESH_PERIOD-1.
  - Expired means count == REFRESH_PERIOD-(N+2). This spaces refresh latch pulses exactly REFRESH_PERIOD cycles apart.
  - Cleared when refresh_en=0.
- frame_valid is ignored while frame_ready=0. The source must hold frame_data and frame_valid until the handshake completes. frame_data is not re-sampled after capture.
- Counter width is clog2(N). The counter wraps to 0 on leaving SHIFT.

## Timing
- Handshake on rising edge E0 (valid & ready both high).
- Cycles E0+1 .. E0+N: sr_en=0, sr_data = bit N-1 down to bit 0. The chain samples each bit at the end of its cycle.
- Cycle E0+N+1: latch=1, sr_en=1.
- Cycle E0+N+2: IDLE, frame_ready=1. A back-to-back frame is accepted at the end of this cycle.
- Minimum frame period: N+2 cycles.
- After latch, the chain holds frame_data exactly: stage CHAIN-1 holds the top WIDTH bits.
- busy = (state != IDLE), which is the same as !frame_ready.
- Reset mid-SHIFT or mid-LATCH:
  - Outputs return immediately to their reset values and no latch pulse is issued.
  - Chain contents are undefined until the next full frame. hold_valid=0, so no refresh occurs until a new frame arrives.
- rst_n release: the first handshake is possible on the first rising edge after deassertion.

## Test plan
- Single frame, WIDTH=8, CHAIN=2, frame_data=16'hA5C3 with a behavioural chain model:
  - Response: sr_en low for exactly 16 cycles, serial bits 1010_0101_1100_0011.
  - latch high one cycle at E0+17; model outputs 16'hA5C3; frame_ready returns at E0+18.
- Back-to-back frames 16'hFFFF then 16'h0001 with frame_valid held high:
  - Response: second handshake exactly 18 cycles after the first; final latched value 16'h0001.
- Valid while busy: toggle frame_data every cycle during SHIFT:
  - Response: serialised bits match only the captured value; no extra handshake.
- Refresh, REFRESH_PERIOD=64, refresh_en=1, one frame 16'h1234:
  - Response: latch pulses every 64 cycles, each re-sending 16'h1234.
  - A new frame arriving on the same cycle as a refresh expiry is sent instead, and the period restarts from its latch.
- Reset mid-SHIFT: assert rst_n=0 after 5 shift cycles:
  - Response: asynchronously sr_en=1, latch=0, frame_ready=1, busy=0; no latch pulse; no refresh until the next frame.
- Reset values check: hold rst_n=0 for 3 cycles with random inputs:
  - Response: all outputs stay at their reset values throughout.

Source files
------------

// File: rtl/led_frame_loader.sv
// -----------------------------------------------------------------------------
// led_frame_loader
//
// Loads a parallel LED frame into a cascaded serial-in shift-register chain,
// MSB first, one bit per clock. When the whole frame has been shifted it
// pulses a one-cycle latch strobe so the drivers update in one step. The last
// accepted frame is held, and can be re-sent periodically to refresh the chain.
//
// Parameters
//   WIDTH          bits per shift-register stage (>= 2)
//   CHAIN          number of cascaded stages; frame length N = WIDTH*CHAIN
//   REFRESH_PERIOD cycles between latch pulses when auto-refreshing (>= N+2)
//
// Ports
//   clk          rising-edge clock shared with the chain
//   rst_n        asynchronous active-low reset
//   frame_data   frame; bit N-1 goes out first and ends in the far stage
//   frame_valid  source has a frame
//   frame_ready  loader can accept a frame (high only in IDLE)
//   refresh_en   enables periodic re-send of the held frame
//   sr_data      serial data to the chain
//   sr_en        active-low shift enable; chain shifts each edge while low
//   latch        one-cycle output-update strobe
//   busy         high while shifting or latching
// -----------------------------------------------------------------------------
module led_frame_loader #(
  parameter int WIDTH          = 8,
  parameter int CHAIN          = 2,
  parameter int REFRESH_PERIOD = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH*CHAIN-1:0]   frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  logic                     refresh_en,
  output logic                     sr_data,
  output logic                     sr_en,
  output logic                     latch,
  output logic                     busy
);

  localparam int N     = WIDTH * CHAIN;
  localparam int CNT_W = $clog2(N);
  localparam int REF_W = $clog2(REFRESH_PERIOD);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] SECOND_BIT = CNT_W'(N - 2);
  localparam logic [REF_W-1:0] REF_MAX    = REF_W'(REFRESH_PERIOD - 1);
  // Expiry is placed N+2 cycles early so that the shift and latch of the
  // re-send land the latch pulse exactly REFRESH_PERIOD after the previous one.
  localparam logic [REF_W-1:0] REF_EXPIRE = REF_W'(REFRESH_PERIOD - N - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     hold_q;
  logic             hold_valid;
  logic [CNT_W-1:0] bit_cnt;
  logic [REF_W-1:0] ref_cnt;

  logic             take_frame;
  logic             start_refresh;
  logic [CNT_W-1:0] next_idx;
  logic             next_bit;

  // NOTE: these decodes look at inputs but only feed register D-inputs, so
  // no output ever has a combinational path from an input.
  assign take_frame    = (state == IDLE) && frame_valid && frame_ready;
  assign start_refresh = (state == IDLE) && refresh_en && hold_valid &&
                         (ref_cnt == REF_EXPIRE);

  // Bit presented in the cycle after the current one; sr_data is registered,
  // so the selection runs one bit ahead of the bit counter.
  assign next_idx = SECOND_BIT - bit_cnt;
  assign next_bit = hold_q[next_idx];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain same-edge updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_q      <= '0;
      hold_valid  <= 1'b0;
      bit_cnt     <= '0;
      frame_ready <= 1'b1;
      sr_en       <= 1'b1;
      sr_data     <= 1'b0;
      latch       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_frame) begin
            // New frame wins over a refresh expiring in the same cycle.
            hold_q      <= frame_data;
            hold_valid  <= 1'b1;
            sr_data     <= frame_data[N-1];
            state       <= SHIFT;
            bit_cnt     <= '0;
            sr_en       <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b1;
          end else if (start_refresh) begin
            sr_data     <= hold_q[N-1];
            state       <= SHIFT;
            bit_cnt     <= '0;
            sr_en       <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            state   <= LATCH;
            bit_cnt <= '0;
            sr_en   <= 1'b1;
            sr_data <= 1'b0;
            latch   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sr_data <= next_bit;
          end
        end
        LATCH: begin
          state       <= IDLE;
          latch       <= 1'b0;
          frame_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bit_cnt     <= '0;
          frame_ready <= 1'b1;
          sr_en       <= 1'b1;
          sr_data     <= 1'b0;
          latch       <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Refresh counter: runs only in IDLE, saturates, and restarts from the
  // latch pulse (or from a newly accepted frame).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (!refresh_en || (state == LATCH) || take_frame) begin
      ref_cnt <= '0;
    end else if ((state == IDLE) && (ref_cnt != REF_MAX)) begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

endmodule
